// File: rtl/crc32_pkg.sv
// Shared constants, state encoding and the serial CRC-32 update for the crc32_engine slice.
package crc32_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      APPEND
   } crc32_state_e;

   // Applies data[width-1] downto data[0], MSB-first, non-reflected.
   function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                              input logic [7:0]  data,
                                              input int          width);
      logic [31:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (i < width) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC32_POLY : 32'h0);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_lfsr.sv
// Combinational DATA_W-bit parallel CRC-32 update built from the unrolled serial step.
module crc32_lfsr
   import crc32_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [31:0]       crc_cur,
   input  logic [DATA_W-1:0] data,
   output logic [31:0]       crc_upd
);

   logic [7:0] data_ext;

   assign data_ext = 8'(data);
   assign crc_upd  = crc32_step(crc_cur, data_ext, DATA_W);

endmodule

// File: rtl/crc32_engine.sv
// Streaming Ethernet CRC-32 generator/checker over DATA_W-bit beats.
// Define CRC32_CHECK_EN to build check mode (chk_done/chk_ok); otherwise every frame generates.
module crc32_engine
   import crc32_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic              sof,
   input  logic              eof,
   output logic [31:0]       crc,
   output logic [31:0]       crc_next,
   output logic [DATA_W-1:0] fcs_data,
   output logic              fcs_valid,
   input  logic              fcs_ready,
   output logic              chk_done,
   output logic              chk_ok,
   output logic              abort
);

   localparam int N = 32 / DATA_W;
   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   if (DATA_W != 4 && DATA_W != 8) begin : gen_bad_width
      $error("crc32_engine: DATA_W must be 4 or 8");
   end

   crc32_state_e      state_q, state_d;
   logic [31:0]       crc_q, crc_d, crc_seed, crc_upd, fcs_shift;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] fcs_data_q, fcs_data_d, fcs_first;
   logic              fcs_valid_q, fcs_valid_d;
   logic              abort_q, abort_d;
   logic              accept, frame_chk, chk_fire;

   assign din_ready = (state_q != APPEND);
   assign accept    = din_valid & din_ready;
   assign crc_seed  = (accept && sof) ? CRC32_INIT : crc_q;

   crc32_lfsr #(
      .DATA_W (DATA_W)
   ) u_lfsr (
      .crc_cur (crc_seed),
      .data    (din),
      .crc_upd (crc_upd)
   );

   assign fcs_first = ~crc_upd[31 -: DATA_W];
   // crc holds during APPEND, so beat k+1 is just the complemented register shifted up.
   assign fcs_shift = ~crc_q << (DATA_W * (int'(cnt_q) + 1));

   always_comb begin
      state_d     = state_q;
      crc_d       = crc_q;
      cnt_d       = cnt_q;
      fcs_valid_d = fcs_valid_q;
      fcs_data_d  = fcs_data_q;
      abort_d     = 1'b0;
      chk_fire    = 1'b0;
      unique case (state_q)
         IDLE, CALC: begin
            if (accept && (sof || state_q == CALC)) begin
               crc_d   = crc_upd;
               abort_d = sof && (state_q == CALC);
               state_d = CALC;
               if (eof) begin
                  if (frame_chk) begin
                     state_d  = IDLE;
                     chk_fire = 1'b1;
                  end else begin
                     state_d     = APPEND;
                     cnt_d       = '0;
                     fcs_valid_d = 1'b1;
                     fcs_data_d  = fcs_first;
                  end
               end
            end
         end
         APPEND: begin
            if (fcs_valid_q && fcs_ready) begin
               if (cnt_q == CNT_LAST) begin
                  state_d     = IDLE;
                  crc_d       = CRC32_INIT;
                  cnt_d       = '0;
                  fcs_valid_d = 1'b0;
                  fcs_data_d  = '0;
               end else begin
                  cnt_d      = cnt_q + 1'b1;
                  fcs_data_d = fcs_shift[31 -: DATA_W];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         crc_q       <= CRC32_INIT;
         cnt_q       <= '0;
         fcs_valid_q <= 1'b0;
         fcs_data_q  <= '0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         crc_q       <= crc_d;
         cnt_q       <= cnt_d;
         fcs_valid_q <= fcs_valid_d;
         fcs_data_q  <= fcs_data_d;
         abort_q     <= abort_d;
      end
   end

`ifdef CRC32_CHECK_EN
   logic mode_q, chk_done_q, chk_ok_q;

   // A sof beat carries its own mode; later beats use the latched one.
   assign frame_chk = sof ? mode : mode_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= 1'b0;
         chk_done_q <= 1'b0;
         chk_ok_q   <= 1'b0;
      end else begin
         if (accept && sof) begin
            mode_q <= mode;
         end
         chk_done_q <= chk_fire;
         chk_ok_q   <= chk_fire && (crc_upd == CRC32_RESIDUE);
      end
   end

   assign chk_done = chk_done_q;
   assign chk_ok   = chk_ok_q;
`else
   logic [1:0] unused_chk;

   assign unused_chk = {mode, chk_fire};
   assign frame_chk  = 1'b0;
   assign chk_done   = 1'b0;
   assign chk_ok     = 1'b0;
`endif

   assign crc       = crc_q;
   assign crc_next  = crc_d;
   assign fcs_data  = fcs_data_q;
   assign fcs_valid = fcs_valid_q;
   assign abort     = abort_q;

endmodule

// File: doc/crc32_engine.md
# crc32_engine

Parametrised Ethernet CRC-32 engine, the successor of the fixed 4-bit MII CRC block. It accepts a frame as a stream of DATA_W-bit beats with start/end markers and has two modes. In generate mode it serialises the complemented FCS onto an output handshake after the last beat. In check mode it compares the final register against the CRC-32 residue. It sits between the MAC framing logic and the PHY-side nibble/byte interface, in both the TX and RX paths.

## Interface
- DATA_W, 8: beat width; legal values 4 and 8 (elaboration error otherwise).
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- mode  in  1  0 = generate, 1 = check; sampled on the sof beat and held internally for the frame.
- din  in  DATA_W  beat data; din[DATA_W-1] is the first serial bit.
- din_valid  in  1  beat present.
- din_ready  out  1  engine accepts a beat; high in IDLE and CALC, low in APPEND.
- sof  in  1  qualifies the beat as the first beat of the frame.
- eof  in  1  qualifies the beat as the last beat of the frame.
- crc  out  32  current CRC register.
- crc_next  out  32  value crc takes at the next edge (combinational).
- fcs_data  out  DATA_W  FCS beat.
- fcs_valid  out  1  FCS beat present.
- fcs_ready  in  1  downstream accepts the FCS beat.
- chk_done  out  1  one-cycle pulse at the end of a check-mode frame.
- chk_ok  out  1  check result; valid while chk_done is high, otherwise 0.
- abort  out  1  one-cycle pulse when a frame is restarted before its eof.

## Operation
- Polynomial 0x04C11DB7, non-reflected, MSB-first shift, init 0xFFFFFFFF.
- Per serial bit b: fb = crc[31]^b; crc = {crc[30:0],1'b0} ^ (fb ? POLY : 0). DATA_W bits are applied per beat, in din[DATA_W-1] downto din[0] order.
- Accepted beat: din_valid & din_ready.
- On an accepted beat with sof, the update is seeded from 0xFFFFFFFF rather than from crc.
- crc holds whenever no beat is accepted.
- States and transitions:
  - IDLE: accepted sof beat → CALC. Accepted beats without sof are discarded, and crc is unchanged.
  - IDLE, with sof&eof on the same beat: single-beat frame; goes directly to the eof handling below.
  - CALC, accepted eof beat in generate mode → APPEND.
  - CALC, accepted eof beat in check mode → IDLE, with chk_done pulsed.
  - CALC, accepted sof beat without a prior eof: abort pulses, crc is reseeded from that beat, and the state stays CALC.
  - APPEND: emits N = 32/DATA_W beats. Beat k: fcs_data = ~crc[31-k*DATA_W -: DATA_W].
  - APPEND, after the last beat is accepted (fcs_valid & fcs_ready) → IDLE; crc is reloaded to 0xFFFFFFFF.
- Check: chk_ok = (crc after the eof update == 0xC704DD7B).
- Beat counter: log2(N) bits, cleared on APPEND entry, wraps to 0 on exit.
- Reset values:
  - state IDLE, crc 0xFFFFFFFF, beat counter 0.
  - fcs_valid 0, fcs_data 0, chk_done 0, chk_ok 0, abort 0.
  - din_ready 1.
- Reset mid-frame or mid-APPEND discards all progress; no chk_done or abort is generated.

## Timing
- crc is updated at the clock edge that accepts a beat. crc_next shows that value in the same cycle.
- chk_done/chk_ok are registered and assert in the cycle after the eof beat is accepted.
- fcs_valid is first asserted in the cycle after the eof beat is accepted.
- fcs_data/fcs_valid are registered and stay stable while fcs_ready=0.
- With fcs_ready held high, the FCS takes exactly N consecutive cycles.
- din_ready drops combinationally in APPEND. A sof offered during APPEND is not accepted and must be held by the source.
- abort is registered, one cycle after the restarting sof beat.

## Configuration
- CRC32_CHECK_EN defined: check mode, chk_done and chk_ok are built.
- CRC32_CHECK_EN undefined:
  - mode is ignored and every frame uses generate mode.
  - chk_done and chk_ok are tied to 0.
  - The residue comparator is removed.

## Structure
- Package crc32_pkg holds:
  - CRC32_POLY, CRC32_INIT and CRC32_RESIDUE.
  - The state enum (IDLE, CALC, APPEND).
  - Function crc32_step(crc, data, width), the unrolled serial update.
- Sub-module crc32_lfsr: combinational DATA_W-bit parallel update wrapping crc32_step. It is instantiated once by crc32_engine.

## Test plan
- DATA_W=8, generate mode, "123456789" fed with each byte bit-reversed on din -> crc=0x9B63D02C after eof, and the 4 FCS beats equal ~0x9B63D02C, MSB byte first.
- DATA_W=4, same message split high nibble first -> identical crc and 8 FCS nibbles that concatenate to the same 32 bits.
- Check mode, the message plus its emitted FCS beats -> chk_done one cycle after eof with chk_ok=1 and crc=0xC704DD7B. With one data bit flipped -> chk_ok=0.
- Backpressure: fcs_ready low for 3 cycles on FCS beat 2 -> fcs_data stable, din_ready=0 throughout, and no beat is lost or duplicated.
- Restart: sof arrives on beat 4 of an unfinished frame -> abort pulse, and the final crc equals the value for the second frame alone.
- rst asserted mid-APPEND -> next cycle fcs_valid=0, crc=0xFFFFFFFF, din_ready=1, and a following frame computes correctly.
